// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM states, prescaler width
// and the layout of the flattened measurement record {period, high, stuck, level}.
package pwm_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_HIGH = 2'd2,
    ST_LOW  = 2'd3
  } cap_state_e;

  localparam int unsigned PRESCALE_W    = 16;
  localparam int unsigned REC_LEVEL_OFS = 0;
  localparam int unsigned REC_STUCK_OFS = 1;
  localparam int unsigned REC_HIGH_OFS  = 2;

  // Total record width for a given counter width.
  function automatic int unsigned rec_width(input int unsigned cnt_w);
    return (2 * cnt_w) + 2;
  endfunction

  // Bit offset of the period field for a given counter width.
  function automatic int unsigned rec_period_ofs(input int unsigned cnt_w);
    return cnt_w + 2;
  endfunction

  // A measurement is in progress while the FSM sits in HIGH or LOW.
  function automatic logic is_busy(input cap_state_e s);
    return (s == ST_HIGH) || (s == ST_LOW);
  endfunction

endpackage

// File: rtl/pwm_tick_gen.sv
// Prescaler for the capture block. The down-counter rests at zero while not
// running, so the first cycle of a run produces a tick and loads prescale.
module pwm_tick_gen
  import pwm_capture_pkg::*;
#(
  parameter int unsigned PS_W = PRESCALE_W
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            run,
  input  logic [PS_W-1:0] prescale,
  output logic            tick
);

  localparam logic [PS_W-1:0] PS_ZERO = {PS_W{1'b0}};
  localparam logic [PS_W-1:0] PS_ONE  = PS_W'(1);

  logic [PS_W-1:0] r_cnt;
  logic            w_at_reload;

  assign w_at_reload = (r_cnt == PS_ZERO);
  assign tick        = run & w_at_reload;

  // Down-counter: reload from prescale at zero, hold at zero while stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= PS_ZERO;
    end else if (!run) begin
      r_cnt <= PS_ZERO;
    end else if (w_at_reload) begin
      r_cnt <= prescale;
    end else begin
      r_cnt <= r_cnt - PS_ONE;
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// PWM period / high-time capture. The pin is synchronised, sampled on prescaler
// ticks, and an FSM counts ticks between rising edges. Finished measurements
// (or stuck-level timeouts) go to the host through a one-entry holding register.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  pwm_in,
  output logic [CNT_W-1:0]      meas_period,
  output logic [CNT_W-1:0]      meas_high,
  output logic                  meas_stuck,
  output logic                  meas_level,
  output logic                  meas_valid,
  input  logic                  meas_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam int unsigned      REC_W      = rec_width(CNT_W);
  localparam int unsigned      PERIOD_OFS = rec_period_ofs(CNT_W);
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_samp;
  cap_state_e       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_hi_lat;
  logic [REC_W-1:0] r_hold;
  logic             r_valid;
  logic             r_overrun;

  logic             w_run;
  logic             w_tick;
  logic             w_rise;
  logic             w_fall;
  logic             w_emit;
  logic [REC_W-1:0] w_rec;

  assign w_run = enable & (r_state != ST_IDLE);

  pwm_tick_gen #(.PS_W(PRESCALE_W)) u_tick_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (w_run),
    .prescale (prescale),
    .tick     (w_tick)
  );

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= pwm_in;
      r_sync2 <= r_sync1;
    end
  end

  // Edge detection against the previous tick sample and assembly of the record to emit.
  always_comb begin
    w_rise = 1'b0;
    w_fall = 1'b0;
    w_emit = 1'b0;
    w_rec  = {REC_W{1'b0}};
    if (w_tick) begin
      w_rise = r_sync2 & ~r_samp;
      w_fall = ~r_sync2 & r_samp;
    end else begin
      w_rise = 1'b0;
      w_fall = 1'b0;
    end
    case (r_state)
      ST_HIGH: begin
        if (w_tick && !w_fall && (r_cnt == CNT_LAST)) begin
          w_emit = 1'b1;
          w_rec  = {CNT_ZERO, CNT_ZERO, 1'b1, r_sync2};
        end else begin
          w_emit = 1'b0;
        end
      end
      ST_LOW: begin
        if (w_rise) begin
          w_emit = 1'b1;
          w_rec  = {r_cnt, r_hi_lat, 1'b0, 1'b0};
        end else if (w_tick && (r_cnt == CNT_LAST)) begin
          w_emit = 1'b1;
          w_rec  = {CNT_ZERO, CNT_ZERO, 1'b1, r_sync2};
        end else begin
          w_emit = 1'b0;
        end
      end
      default: w_emit = 1'b0;
    endcase
  end

  // Measurement FSM: advances on ticks; dropping enable abandons any partial measurement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_hi_lat <= CNT_ZERO;
      r_samp   <= 1'b0;
    end else if (!enable) begin
      r_state  <= ST_IDLE;
      r_cnt    <= CNT_ZERO;
      r_hi_lat <= CNT_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // Preload the current level so arming never sees a false edge.
          r_samp  <= r_sync2;
          r_state <= ST_ARM;
        end
        ST_ARM: begin
          if (w_tick) begin
            r_samp <= r_sync2;
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_state <= ST_HIGH;
            end
          end
        end
        ST_HIGH: begin
          if (w_tick) begin
            r_samp <= r_sync2;
            if (w_fall) begin
              r_hi_lat <= r_cnt;
              r_cnt    <= r_cnt + CNT_ONE;
              r_state  <= ST_LOW;
            end else if (r_cnt == CNT_LAST) begin
              r_cnt   <= CNT_ZERO;
              r_state <= ST_ARM;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        ST_LOW: begin
          if (w_tick) begin
            r_samp <= r_sync2;
            if (w_rise) begin
              r_cnt   <= CNT_ONE;
              r_state <= ST_HIGH;
            end else if (r_cnt == CNT_LAST) begin
              r_cnt   <= CNT_ZERO;
              r_state <= ST_ARM;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // One-entry holding register with sticky overrun; clear beats a simultaneous emit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold    <= {REC_W{1'b0}};
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (clear) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_emit) begin
      if (!r_valid || meas_ready) begin
        r_hold  <= w_rec;
        r_valid <= 1'b1;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (r_valid && meas_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign meas_period = r_hold[PERIOD_OFS +: CNT_W];
  assign meas_high   = r_hold[REC_HIGH_OFS +: CNT_W];
  assign meas_stuck  = r_hold[REC_STUCK_OFS];
  assign meas_level  = r_hold[REC_LEVEL_OFS];
  assign meas_valid  = r_valid;
  assign overrun     = r_overrun;
  assign busy        = is_busy(r_state);

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture. Pin waveforms are built from whole tick counts; the
// reference model predicts each record as {high+low ticks, high ticks} for every
// period closed by a following rising edge, plus explicit stuck records.
module tb_pwm_capture;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] high;
    logic        stuck;
    logic        level;
  } rec_t;

  logic        clk        = 1'b0;
  logic        reset_n    = 1'b0;
  logic        enable     = 1'b0;
  logic        clear      = 1'b0;
  logic [15:0] prescale   = 16'd0;
  logic        pwm_in     = 1'b0;
  logic        meas_ready = 1'b0;
  logic [15:0] meas_period;
  logic [15:0] meas_high;
  logic        meas_stuck;
  logic        meas_level;
  logic        meas_valid;
  logic        overrun;
  logic        busy;

  int   n_checks = 0;
  int   n_pass   = 0;
  rec_t exp_q[$];
  rec_t obs_q[$];

  always #5 clk = ~clk;

  pwm_capture #(.CNT_W(16), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clear       (clear),
    .prescale    (prescale),
    .pwm_in      (pwm_in),
    .meas_period (meas_period),
    .meas_high   (meas_high),
    .meas_stuck  (meas_stuck),
    .meas_level  (meas_level),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  // Record every handshake the host completes.
  always @(negedge clk) begin
    rec_t r;
    if (reset_n && meas_valid && meas_ready) begin
      r = {meas_period, meas_high, meas_stuck, meas_level};
      obs_q.push_back(r);
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_train(input int p);
    prescale = 16'(p);
    pwm_in   = 1'b0;
    wait_clk(2);
    enable = 1'b1;
    wait_clk(4 * (p + 1));
  endtask

  task automatic drive_period(input int p, input int h, input int l);
    rec_t r;
    pwm_in = 1'b1;
    wait_clk(h * (p + 1));
    pwm_in = 1'b0;
    wait_clk(l * (p + 1));
    r.period = 16'(h + l);
    r.high   = 16'(h);
    r.stuck  = 1'b0;
    r.level  = 1'b0;
    exp_q.push_back(r);
  endtask

  task automatic close_train(input int p);
    pwm_in = 1'b1;
    wait_clk(3 * (p + 1) + 4);
    enable = 1'b0;
    pwm_in = 1'b0;
    wait_clk(4);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    wait_clk(3);
    n_checks++;
    if ({meas_period, meas_high, meas_stuck, meas_level, meas_valid, overrun, busy} !== 37'd0)
      $display("FAIL reset_outputs: got %h, expected 0",
               {meas_period, meas_high, meas_stuck, meas_level, meas_valid, overrun, busy});
    else n_pass++;
    reset_n = 1'b1;
    wait_clk(2);
    n_checks++;
    if ({meas_valid, overrun, busy} !== 3'b000)
      $display("FAIL post_reset_idle: got valid/overrun/busy=%b, expected 000", {meas_valid, overrun, busy});
    else n_pass++;
  endtask

  task automatic test_basic();
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b1;
    start_train(0);
    for (int k = 0; k < 4; k++) begin
      drive_period(0, 3, 7);
      if (k == 0) begin
        n_checks++;
        if (obs_q.size() !== 0)
          $display("FAIL t1_no_early_record: got %0d records, expected 0", obs_q.size());
        else n_pass++;
      end
    end
    close_train(0);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL t1_count: got %0d records, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL t1_rec%0d: got p=%0d h=%0d s=%0b l=%0b, expected p=%0d h=%0d s=%0b l=%0b", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].stuck, obs_q[i].level,
                 exp_q[i].period, exp_q[i].high, exp_q[i].stuck, exp_q[i].level);
      else n_pass++;
    end
  endtask

  task automatic test_prescale();
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b1;
    start_train(639);
    drive_period(639, 2, 8);
    drive_period(639, 2, 8);
    close_train(639);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL t2_count: got %0d records, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL t2_rec%0d: got p=%0d h=%0d, expected p=%0d h=%0d", i,
                 obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int p;
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b1;
    p = int'($urandom_range(0, 3));
    start_train(p);
    for (int k = 0; k < 6; k++)
      drive_period(p, int'($urandom_range(1, 6)), int'($urandom_range(1, 6)));
    close_train(p);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL rand_count: got %0d records, expected %0d (prescale %0d)", obs_q.size(), exp_q.size(), p);
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL rand_rec%0d: got p=%0d h=%0d, expected p=%0d h=%0d (prescale %0d)", i,
                 obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high, p);
      else n_pass++;
    end
  endtask

  task automatic test_overrun();
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b0;
    start_train(0);
    drive_period(0, 4, 3);
    drive_period(0, 2, 5);
    drive_period(0, 5, 1);
    close_train(0);
    n_checks++;
    if ({meas_valid, overrun} !== 2'b11)
      $display("FAIL t3_full: got valid/overrun=%b, expected 11", {meas_valid, overrun});
    else n_pass++;
    n_checks++;
    if ({meas_period, meas_high} !== {exp_q[0].period, exp_q[0].high})
      $display("FAIL t3_held_rec: got p=%0d h=%0d, expected p=%0d h=%0d",
               meas_period, meas_high, exp_q[0].period, exp_q[0].high);
    else n_pass++;
    clear = 1'b1;
    wait_clk(1);
    clear = 1'b0;
    wait_clk(1);
    n_checks++;
    if ({meas_valid, overrun} !== 2'b00)
      $display("FAIL t3_clear: got valid/overrun=%b, expected 00", {meas_valid, overrun});
    else n_pass++;
    meas_ready = 1'b1;
  endtask

  task automatic test_timeout();
    rec_t r;
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b1;
    start_train(0);
    pwm_in = 1'b1;
    wait_clk(10);
    n_checks++;
    if (busy !== 1'b1) $display("FAIL t4_busy_high: got %b, expected 1", busy);
    else n_pass++;
    wait_clk(20);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL t4_armed_after_timeout: got busy=%b, expected 0", busy);
    else n_pass++;
    r.period = 16'd0; r.high = 16'd0; r.stuck = 1'b1; r.level = 1'b1;
    exp_q.push_back(r);
    pwm_in = 1'b0;
    wait_clk(4);
    drive_period(0, 3, 5);
    close_train(0);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL t4_count: got %0d records, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL t4_rec%0d: got p=%0d h=%0d s=%0b l=%0b, expected p=%0d h=%0d s=%0b l=%0b", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].stuck, obs_q[i].level,
                 exp_q[i].period, exp_q[i].high, exp_q[i].stuck, exp_q[i].level);
      else n_pass++;
    end
  endtask

  task automatic test_enable_drop();
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b1;
    start_train(0);
    pwm_in = 1'b1;
    wait_clk(5);
    enable = 1'b0;
    wait_clk(3);
    n_checks++;
    if (busy !== 1'b0) $display("FAIL t5_idle_busy: got %b, expected 0", busy);
    else n_pass++;
    enable = 1'b1;
    wait_clk(5);
    pwm_in = 1'b0;
    wait_clk(4);
    drive_period(0, 3, 6);
    close_train(0);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL t5_count: got %0d records, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL t5_rec%0d: got p=%0d h=%0d s=%0b, expected p=%0d h=%0d s=%0b", i,
                 obs_q[i].period, obs_q[i].high, obs_q[i].stuck,
                 exp_q[i].period, exp_q[i].high, exp_q[i].stuck);
      else n_pass++;
    end
    n_checks++;
    if (overrun !== 1'b0) $display("FAIL t5_overrun: got %b, expected 0", overrun);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int p;
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b0;
    start_train(0);
    drive_period(0, 3, 5);
    pwm_in = 1'b1;
    wait_clk(6);
    pwm_in = 1'b0;
    wait_clk(4);
    n_checks++;
    if ({meas_valid, busy} !== 2'b11)
      $display("FAIL t6_pre_state: got valid/busy=%b, expected 11", {meas_valid, busy});
    else n_pass++;
    #3 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({meas_period, meas_high, meas_stuck, meas_level, meas_valid, overrun, busy} !== 37'd0)
      $display("FAIL t6_async_reset: got %h, expected 0",
               {meas_period, meas_high, meas_stuck, meas_level, meas_valid, overrun, busy});
    else n_pass++;
    enable = 1'b0;
    wait_clk(3);
    reset_n = 1'b1;
    wait_clk(2);
    exp_q.delete(); obs_q.delete();
    meas_ready = 1'b1;
    p = int'($urandom_range(0, 2));
    start_train(p);
    for (int k = 0; k < 3; k++)
      drive_period(p, int'($urandom_range(1, 5)), int'($urandom_range(1, 5)));
    close_train(p);
    n_checks++;
    if (obs_q.size() !== exp_q.size())
      $display("FAIL t6_count: got %0d records, expected %0d", obs_q.size(), exp_q.size());
    else n_pass++;
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_checks++;
      if (obs_q[i] !== exp_q[i])
        $display("FAIL t6_rec%0d: got p=%0d h=%0d, expected p=%0d h=%0d", i,
                 obs_q[i].period, obs_q[i].high, exp_q[i].period, exp_q[i].high);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prescale();
    test_random();
    test_overrun();
    test_timeout();
    test_enable_drop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
